zpu_sd_bridge: RTL and testbench

//  Sector-I/O bridge between the ZPU firmware register port (ZPU_OUT2/OUT3, ZPU_IN2/IN3, ZPU_RD/WR strobes) and the hps_io sd_* block interface.

---
 rtl/zpu_sd_pkg.sv | 20 ++
 rtl/zpu_sd_buf.sv | 28 ++
 rtl/zpu_sd_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_zpu_sd_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/zpu_sd_pkg.sv
// rtl/zpu_sd_pkg.sv - shared types and constants for the ZPU sector-I/O bridge
package zpu_sd_pkg;

  // Block transfer sequencing towards hps_io
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } fsm_e;

  // Bit positions inside the ZPU_IN2 status byte
  localparam int STAT_IO_DONE      = 0;
  localparam int STAT_MOUNTED      = 1;
  localparam int STAT_FILENO_LSB   = 2;
  localparam int STAT_FILETYPE_LSB = 5;
  localparam int STAT_READONLY     = 7;

  localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/zpu_sd_buf.sv
// rtl/zpu_sd_buf.sv - true dual-port 8-bit sector buffer, port A hps side, port B ZPU side
module zpu_sd_buf
  import zpu_sd_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [7:0]    a_wdata_i,
  input  logic          a_we_i,
  output logic [7:0]    a_q_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic [7:0]    b_wdata_i,
  input  logic          b_we_i,
  output logic [7:0]    b_q_o
);

  logic [7:0] mem [2**AW];

  // Both ports in one process; read-before-write, port B wins a same-address collision
  always_ff @(posedge clk_i) begin
    if (a_we_i) mem[a_addr_i] <= a_wdata_i;
    if (b_we_i) mem[b_addr_i] <= b_wdata_i;
    a_q_o <= mem[a_addr_i];
    b_q_o <= mem[b_addr_i];
  end

endmodule

// File: rtl/zpu_sd_bridge.sv
// rtl/zpu_sd_bridge.sv - ZPU register port to hps_io sd block bridge; ZPU_SD_WRITE_EN enables sector writes
module zpu_sd_bridge
  import zpu_sd_pkg::*;
#(
  parameter int BUF_AW = 9,
  parameter int SIZE_W = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              zpu_lba,
  input  logic              zpu_block_rd,
  input  logic              zpu_block_wr,
  input  logic              zpu_io_wr,
  input  logic              zpu_data_wr,
  input  logic              zpu_data_rd,
  input  logic [SIZE_W-1:0] zpu_wdata,
  output logic [7:0]        zpu_status,
  output logic [SIZE_W-1:0] zpu_rdata,
  output logic [SIZE_W-1:0] sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [BUF_AW-1:0] sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  input  logic              img_mounted,
  input  logic [63:0]       img_size,
  input  logic [7:0]        ioctl_index
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_XFER = XFER;

`ifdef ZPU_SD_WRITE_EN
  localparam logic READONLY = 1'b0;
`else
  localparam logic READONLY = 1'b1;
`endif

  logic              wr_d1_q, wr_d2_q, rd_d1_q;
  logic              brd_d1_q, bwr_d1_q, ack_d1_q, mnt_d1_q;
  logic              wr_edge, rd_fall, brd_rise, bwr_rise, ack_fall, mnt_rise;
  logic [BUF_AW-1:0] ptr_q, ptr_d;
  logic              inc_pend_q;
  logic              buf_we;
  logic [7:0]        buf_q;
  logic [1:0]        state_q, state_d;
  logic              sd_rd_q, sd_rd_d;
  logic              sd_wr_q, sd_wr_d;
  logic              io_done_q, io_done_d;
  logic              ro_pend_q, ro_pend_d;
  logic              mounted_q;
  logic [2:0]        fileno_q;
  logic [1:0]        filetype_q;
  logic [SIZE_W-1:0] filesize_q;
  logic [SIZE_W-1:0] sd_lba_q;
  logic              unused_bits;

  // Only the low image-size bits and the filetype field of ioctl_index matter here
  assign unused_bits = ^{img_size, ioctl_index};

  // Input history for edge detection; tracks through reset so held levels never look like edges
  always_ff @(posedge clk_sys) begin
    wr_d1_q  <= zpu_data_wr;
    wr_d2_q  <= wr_d1_q;
    rd_d1_q  <= zpu_data_rd;
    brd_d1_q <= zpu_block_rd;
    bwr_d1_q <= zpu_block_wr;
    ack_d1_q <= sd_ack;
    mnt_d1_q <= img_mounted;
  end

  assign wr_edge  = wr_d1_q & ~wr_d2_q;
  assign rd_fall  = rd_d1_q & ~zpu_data_rd;
  assign brd_rise = zpu_block_rd & ~brd_d1_q;
  assign bwr_rise = zpu_block_wr & ~bwr_d1_q;
  assign ack_fall = ack_d1_q & ~sd_ack;
  assign mnt_rise = img_mounted & ~mnt_d1_q;
  assign buf_we   = wr_edge & ~zpu_lba & ~reset;

  // Byte pointer: io_wr clear beats any increment; data writes advance it one cycle after the RAM write
  always_comb begin
    ptr_d = ptr_q;
    if (inc_pend_q || rd_fall) ptr_d = ptr_q + BUF_AW'(1);
    if (zpu_io_wr) ptr_d = '0;
  end

  // Pointer, deferred write increment and LBA register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ptr_q      <= '0;
      inc_pend_q <= 1'b0;
      sd_lba_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inc_pend_q <= buf_we;
      if (wr_edge && zpu_lba) sd_lba_q <= zpu_wdata;
    end
  end

  // Block request sequencing; a read edge wins over a same-cycle write edge
  always_comb begin
    state_d   = state_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    io_done_d = io_done_q;
    ro_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ro_pend_q) io_done_d = 1'b1;
        if (brd_rise) begin
          state_d   = ST_REQ;
          io_done_d = 1'b0;
          sd_rd_d   = 1'b1;
        end else if (bwr_rise) begin
          io_done_d = 1'b0;
`ifdef ZPU_SD_WRITE_EN
          state_d   = ST_REQ;
          sd_wr_d   = 1'b1;
`else
          // Read-only image: complete immediately without touching hps_io
          ro_pend_d = 1'b1;
`endif
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          state_d = ST_XFER;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (ack_fall) begin
          state_d   = ST_IDLE;
          io_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and request/done registers; reset drops any in-flight request
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      io_done_q <= 1'b0;
      ro_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      io_done_q <= io_done_d;
      ro_pend_q <= ro_pend_d;
    end
  end

  // Mount tracking; reset reloads mounted from the current image size and beats a mount edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mounted_q  <= |img_size[31:0];
      fileno_q   <= '0;
      filetype_q <= '0;
      filesize_q <= '0;
    end else if (mnt_rise) begin
      mounted_q  <= ~mounted_q;
      fileno_q   <= '0;
      filetype_q <= ioctl_index[7:6];
      filesize_q <= img_size[SIZE_W-1:0];
    end
  end

  zpu_sd_buf #(
    .AW(BUF_AW)
  ) u_buf (
    .clk_i     (clk_sys),
    .a_addr_i  (sd_buff_addr),
    .a_wdata_i (sd_buff_dout),
    .a_we_i    (sd_buff_wr),
    .a_q_o     (sd_buff_din),
    .b_addr_i  (ptr_q),
    .b_wdata_i (zpu_wdata[7:0]),
    .b_we_i    (buf_we),
    .b_q_o     (buf_q)
  );

  // Status byte assembled from registered flags
  always_comb begin
    zpu_status                                  = '0;
    zpu_status[STAT_IO_DONE]                    = io_done_q;
    zpu_status[STAT_MOUNTED]                    = mounted_q;
    zpu_status[STAT_FILENO_LSB +: 3]            = fileno_q;
    zpu_status[STAT_FILETYPE_LSB +: 2]          = filetype_q;
    zpu_status[STAT_READONLY]                   = READONLY;
  end

  assign zpu_rdata = zpu_lba ? filesize_q : SIZE_W'(buf_q);
  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// tb/tb_zpu_sd_bridge.sv - directed self-checking bench for zpu_sd_bridge
module tb_zpu_sd_bridge;

`ifdef ZPU_SD_WRITE_EN
  localparam logic [7:0] RO = 8'h00;
`else
  localparam logic [7:0] RO = 8'h80;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        zpu_lba, zpu_block_rd, zpu_block_wr, zpu_io_wr, zpu_data_wr, zpu_data_rd;
  logic [31:0] zpu_wdata;
  logic [7:0]  zpu_status;
  logic [31:0] zpu_rdata;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        img_mounted;
  logic [63:0] img_size;
  logic [7:0]  ioctl_index;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  zpu_sd_bridge #(.BUF_AW(9), .SIZE_W(32)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .zpu_lba      (zpu_lba),
    .zpu_block_rd (zpu_block_rd),
    .zpu_block_wr (zpu_block_wr),
    .zpu_io_wr    (zpu_io_wr),
    .zpu_data_wr  (zpu_data_wr),
    .zpu_data_rd  (zpu_data_rd),
    .zpu_wdata    (zpu_wdata),
    .zpu_status   (zpu_status),
    .zpu_rdata    (zpu_rdata),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .ioctl_index  (ioctl_index)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic write_byte(input logic [31:0] v);
    zpu_wdata   = v;
    zpu_data_wr = 1'b1;
    tick();
    zpu_data_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_pulse();
    zpu_data_rd = 1'b1;
    tick();
    zpu_data_rd = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    zpu_lba = 1'b0; zpu_block_rd = 1'b0; zpu_block_wr = 1'b0; zpu_io_wr = 1'b0;
    zpu_data_wr = 1'b0; zpu_data_rd = 1'b0; zpu_wdata = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    img_mounted = 1'b0; img_size = '0; ioctl_index = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_sd_lba", sd_lba, 0);
    check("rst_status", zpu_status, RO);
    zpu_lba = 1'b1;
    #1 check("rst_filesize", zpu_rdata, 0);

    // LBA write leaves the pointer alone
    write_byte(32'h0000_1234);
    check("lba_write", sd_lba, 32'h1234);
    zpu_lba = 1'b0;
    write_byte(32'h0000_00A5);
    sd_buff_addr = 9'd0;
    tick();
    check("ptr_after_lba", sd_buff_din, 8'hA5);

    // Buffer fill with wrap, then readback from both ports
    zpu_io_wr = 1'b1;
    tick();
    zpu_io_wr = 1'b0;
    tick();
    for (int i = 0; i < 512; i++) write_byte(32'(i & 8'hFF));
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      tick();
      check("rd_zpu", zpu_rdata, 64'(i & 8'hFF));
      check("rd_hps", sd_buff_din, 64'(i & 8'hFF));
      read_pulse();
    end

    // Block write: read-only completes locally, write build issues a request
    zpu_block_wr = 1'b1;
`ifdef ZPU_SD_WRITE_EN
    tick();
    check("bwr_req", sd_wr, 1);
    sd_ack = 1'b1;
    tick();
    check("bwr_req_clr", sd_wr, 0);
    sd_ack = 1'b0;
    tick();
    check("bwr_done", zpu_status[0], 1);
`else
    tick();
    check("ro_sd_wr0", sd_wr, 0);
    check("ro_done_lo", zpu_status[0], 0);
    tick();
    check("ro_sd_wr1", sd_wr, 0);
    check("ro_done_hi", zpu_status[0], 1);
`endif
    zpu_block_wr = 1'b0;
    tick();

    // Read cycle with long ack; second block_rd edge during XFER ignored
    zpu_block_rd = 1'b1;
    tick();
    check("brd_req", sd_rd, 1);
    check("brd_done_clr", zpu_status[0], 0);
    sd_ack = 1'b1;
    zpu_block_rd = 1'b0;
    tick();
    check("brd_req_clr", sd_rd, 0);
    for (int i = 0; i < 599; i++) begin
      if (i == 300) zpu_block_rd = 1'b1;
      tick();
    end
    check("xfer_ignore_rd", sd_rd, 0);
    check("xfer_busy", zpu_status[0], 0);
    sd_ack = 1'b0;
    tick();
    check("xfer_done", zpu_status[0], 1);
    zpu_block_rd = 1'b0;
    tick();

    // Simultaneous edges: read wins
    zpu_block_rd = 1'b1;
    zpu_block_wr = 1'b1;
    tick();
    check("both_rd", sd_rd, 1);
    check("both_wr", sd_wr, 0);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    check("both_done", zpu_status[0], 1);
    zpu_block_rd = 1'b0;
    zpu_block_wr = 1'b0;
    tick();

    // Mount
    check("pre_mount", zpu_status, RO | 8'h01);
    ioctl_index = 8'hC0;
    img_size    = 64'h8000;
    img_mounted = 1'b1;
    tick();
    check("mount1", zpu_status, RO | 8'h63);
    zpu_lba = 1'b1;
    #1 check("mount_size", zpu_rdata, 32'h8000);
    zpu_lba = 1'b0;
    img_mounted = 1'b0;
    tick();
    img_mounted = 1'b1;
    tick();
    check("mount2", zpu_status, RO | 8'h61);
    img_mounted = 1'b0;
    tick();

    // Reset during REQ, with a mount edge in the same cycle
    zpu_block_rd = 1'b1;
    tick();
    check("req_before_rst", sd_rd, 1);
    img_size    = '0;
    img_mounted = 1'b1;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_req_drop", sd_rd, 0);
    check("rst_mid_status", zpu_status, RO);
    zpu_lba = 1'b1;
    #1 check("rst_mid_size", zpu_rdata, 0);
    zpu_lba = 1'b0;
    zpu_block_rd = 1'b0;
    tick();
    check("post_rst_status", zpu_status, RO);
    zpu_block_rd = 1'b1;
    tick();
    check("post_rst_idle", sd_rd, 1);
    check("post_rst_sd_wr", sd_wr, 0);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    check("post_rst_done", zpu_status, RO | 8'h01);
    zpu_block_rd = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
